// File: rtl/ifu.sv
// Instruction fetch unit: holds the PC, issues one instruction-memory read at a time,
// and presents the returned instruction with its PC to decode on a valid/ready handshake.
module ifu #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           INST_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    output logic                  o_mem_rd_en,
    output logic [DATA_WIDTH-1:0] o_mem_rd_addr,
    input  logic                  i_mem_rd_ready,
    input  logic                  i_mem_rd_valid,
    input  logic [INST_WIDTH-1:0] i_mem_rd_data,
    input  logic                  i_jmp_en,
    input  logic [DATA_WIDTH-1:0] i_jmp_pc,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [INST_WIDTH-1:0] o_inst,
    output logic [DATA_WIDTH-1:0] o_pc
);

    localparam int unsigned           PC_STEP  = 4;
    localparam logic [INST_WIDTH-1:0] NOP_INST = INST_WIDTH'(32'h0000_0013);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] pc_next;
    logic                  r_flush;
    logic                  flush_next;
    logic                  valid_next;
    logic [INST_WIDTH-1:0] inst_next;
    logic [DATA_WIDTH-1:0] out_pc_next;
    logic                  rd_en_next;
    logic                  req_accept;
    logic [DATA_WIDTH-1:0] jmp_target;

    // Redirect targets are forced word-aligned.
    assign jmp_target    = i_jmp_pc & ~DATA_WIDTH'(3);
    assign req_accept    = o_mem_rd_en & i_mem_rd_ready;
    assign o_mem_rd_addr = r_pc;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= S_REQ;
            r_pc        <= RESET_PC;
            r_flush     <= 1'b0;
            o_valid     <= 1'b0;
            o_inst      <= NOP_INST;
            o_pc        <= RESET_PC;
            o_mem_rd_en <= 1'b0;
        end else begin
            state       <= state_next;
            r_pc        <= pc_next;
            r_flush     <= flush_next;
            o_valid     <= valid_next;
            o_inst      <= inst_next;
            o_pc        <= out_pc_next;
            o_mem_rd_en <= rd_en_next;
        end
    end

    // Next-state logic; a redirect overrides every other transition.
    always_comb begin
        state_next  = state;
        pc_next     = r_pc;
        flush_next  = r_flush;
        valid_next  = o_valid;
        inst_next   = o_inst;
        out_pc_next = o_pc;

        case (state)
            S_REQ: begin
                if (req_accept) begin
                    state_next = S_WAIT;
                    flush_next = i_jmp_en;
                end
                if (i_jmp_en) begin
                    pc_next = jmp_target;
                end
            end
            S_WAIT: begin
                if (i_mem_rd_valid) begin
                    state_next = S_REQ;
                    flush_next = 1'b0;
                    if (i_jmp_en) begin
                        pc_next = jmp_target;
                    end else if (!r_flush) begin
                        state_next  = S_HOLD;
                        valid_next  = 1'b1;
                        inst_next   = i_mem_rd_data;
                        out_pc_next = r_pc;
                        pc_next     = r_pc + DATA_WIDTH'(PC_STEP);
                    end
                end else if (i_jmp_en) begin
                    flush_next = 1'b1;
                    pc_next    = jmp_target;
                end
            end
            S_HOLD: begin
                if (i_jmp_en) begin
                    state_next = S_REQ;
                    valid_next = 1'b0;
                    pc_next    = jmp_target;
                end else if (i_ready) begin
                    state_next = S_REQ;
                    valid_next = 1'b0;
                end
            end
            default: begin
                state_next = S_REQ;
            end
        endcase

        // Request strobe is registered from the state we are about to enter.
        rd_en_next = (state_next == S_REQ);
    end

endmodule
